nor_dbnc_gea1: RTL and testbench

Parametrised, registered multi-channel NOR cell with input synchronisation and per-channel glitch filtering; successor to the fixed two-input combinational NOR generic cell. Each of CHANNELS outputs is the NOR of WIDTH asynchronous input bits, passed through a synchroniser and then only allowed to change after the result has been stable for FILT_CNT cycles. The cell sits at chip-level boundaries where raw pin, status or wake-up lines are combined and must reach the core clean and glitch-free.

---
 rtl/nor_gea_pkg.sv | 20 ++
 rtl/nor_dbnc_ch_gea1.sv | 63 ++++++
 rtl/nor_dbnc_gea1.sv | 58 +++++
 tb/tb_nor_dbnc_gea1.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nor_gea_pkg.sv
// Shared constants and helpers for the generic NOR cell family.
// The range-check macro is used inside module bodies to reject illegal parameter sets at elaboration.
`ifndef NOR_GEA_RANGE_CHECK
`define NOR_GEA_RANGE_CHECK(p, lo, hi) \
  if (((p) < (lo)) || ((p) > (hi))) begin \
    $error("nor_gea: parameter out of range"); \
  end
`endif

package nor_gea_pkg;

  // Output value after reset: NOR of all-zero synchronised inputs.
  localparam logic Y_RST = 1'b1;

  // Counter width for a FILT_CNT-cycle stability filter, never narrower than one bit.
  function automatic int cnt_w(input int filt_cnt);
    return (filt_cnt <= 2) ? 1 : $clog2(filt_cnt);
  endfunction

endpackage

// File: rtl/nor_dbnc_ch_gea1.sv
// One NOR channel: combinational NOR of the synchronised bits, stability counter and y/chg registers.
module nor_dbnc_ch_gea1
  import nor_gea_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int FILT_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bypass,
  input  logic [WIDTH-1:0] a_sync,
  output logic             y,
  output logic             y_raw,
  output logic             chg
);

  localparam int               CNT_W    = cnt_w(FILT_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             y_d;
  logic             chg_d;

  assign y_raw = ~|a_sync;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    y_d   = y;
    chg_d = 1'b0;
    if (en) begin
      if (bypass) begin
        cnt_d = '0;
        y_d   = y_raw;
        chg_d = y_raw ^ y;
      end else if (y_raw == y) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        y_d   = y_raw;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
      y     <= Y_RST;
      chg   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      y     <= y_d;
      chg   <= chg_d;
    end
  end

endmodule

// File: rtl/nor_dbnc_gea1.sv
// Multi-channel registered NOR with input synchronisers and per-channel glitch filters.
// The top owns the flat synchroniser array; each channel gets its slice of the last stage.
module nor_dbnc_gea1
  import nor_gea_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic                      en,
  input  logic                      bypass,
  output logic [CHANNELS-1:0]       y,
  output logic [CHANNELS-1:0]       y_raw,
  output logic [CHANNELS-1:0]       chg
);

  `NOR_GEA_RANGE_CHECK(CHANNELS, 1, 32)
  `NOR_GEA_RANGE_CHECK(WIDTH, 1, 16)
  `NOR_GEA_RANGE_CHECK(SYNC_STAGES, 1, 4)
  `NOR_GEA_RANGE_CHECK(FILT_CNT, 1, 255)

  localparam int N = CHANNELS * WIDTH;

  logic [SYNC_STAGES-1:0][N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: synchroniser flops are reset so y_raw is a defined all-ones value out of reset.
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= a;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    nor_dbnc_ch_gea1 #(
      .WIDTH    (WIDTH),
      .FILT_CNT (FILT_CNT)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .bypass (bypass),
      .a_sync (sync_q[SYNC_STAGES-1][c*WIDTH +: WIDTH]),
      .y      (y[c]),
      .y_raw  (y_raw[c]),
      .chg    (chg[c])
    );
  end

endmodule

// File: tb/tb_nor_dbnc_gea1.sv
// Scoreboard bench: a window-based reference model pushes expected outputs each edge,
// a negedge monitor pops and compares. A second minimal instance checks the 1/1/1/1 corner.
module tb_nor_dbnc_gea1;

  localparam int CH = 4;
  localparam int W  = 2;
  localparam int SS = 2;
  localparam int FC = 4;
  localparam int N  = CH * W;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          en     = 1'b0;
  logic          bypass = 1'b0;
  logic [N-1:0]  a      = '0;
  logic [CH-1:0] y, y_raw, chg;
  logic          a1     = 1'b0;
  logic          y1, y_raw1, chg1;

  nor_dbnc_gea1 #(
    .CHANNELS(CH), .WIDTH(W), .SYNC_STAGES(SS), .FILT_CNT(FC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .en(en), .bypass(bypass),
    .y(y), .y_raw(y_raw), .chg(chg)
  );

  nor_dbnc_gea1 #(
    .CHANNELS(1), .WIDTH(1), .SYNC_STAGES(1), .FILT_CNT(1)
  ) dut_min (
    .clk(clk), .rst_n(rst_n), .a(a1), .en(1'b1), .bypass(1'b0),
    .y(y1), .y_raw(y_raw1), .chg(chg1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] y;
    logic [CH-1:0] y_raw;
    logic [CH-1:0] chg;
    logic          y1;
    logic          y_raw1;
    logic          chg1;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_err    = 0;

  // Reference model state
  logic [N-1:0]  a_hist[$];   // raw samples still travelling through the synchroniser, oldest first
  logic [CH-1:0] s_hist[$];   // s samples seen at filtering edges since the last clear
  logic [CH-1:0] y_m, chg_m;
  logic          a1_prev, y1_m, chg1_m;

  function automatic logic [CH-1:0] nor_ch(input logic [N-1:0] v);
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = ~|v[c*W +: W];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    a_hist.delete();
    for (int i = 0; i < SS; i++) a_hist.push_back('0);
    s_hist.delete();
    y_m     = '1;
    chg_m   = '0;
    a1_prev = 1'b0;
    y1_m    = 1'b1;
    chg1_m  = 1'b0;
  endtask

  // An output flips once the last FC filtering samples of s all disagree with it.
  task automatic model_edge();
    logic [CH-1:0] s;
    logic          all_diff;
    s = nor_ch(a_hist[0]);
    void'(a_hist.pop_front());
    a_hist.push_back(a);
    chg_m = '0;
    if (en) begin
      if (bypass) begin
        chg_m = s ^ y_m;
        y_m   = s;
        s_hist.delete();
      end else begin
        s_hist.push_back(s);
        if (s_hist.size() > FC) void'(s_hist.pop_front());
        if (s_hist.size() == FC) begin
          for (int c = 0; c < CH; c++) begin
            all_diff = 1'b1;
            foreach (s_hist[k]) if (s_hist[k][c] == y_m[c]) all_diff = 1'b0;
            if (all_diff) begin
              y_m[c]   = ~y_m[c];
              chg_m[c] = 1'b1;
            end
          end
        end
      end
    end
    // Minimal instance: registered inverter of the input sampled one edge earlier.
    chg1_m  = (~a1_prev) != y1_m;
    y1_m    = ~a1_prev;
    a1_prev = a1;
  endtask

  function automatic exp_t exp_now();
    exp_t e;
    e.y      = y_m;
    e.y_raw  = nor_ch(a_hist[0]);
    e.chg    = chg_m;
    e.y1     = y1_m;
    e.y_raw1 = ~a1_prev;
    e.chg1   = chg1_m;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    exp_q.push_back(exp_now());
    #1;
  endtask

  // Called just after an edge; reset takes effect asynchronously.
  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    check("async_rst_y", 32'(y), 32'(y_m));
    check("async_rst_chg", 32'(chg), 32'(chg_m));
    check("async_rst_y1", 32'(y1), 32'(y1_m));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("y", 32'(y), 32'(e.y));
      check("y_raw", 32'(y_raw), 32'(e.y_raw));
      check("chg", 32'(chg), 32'(e.chg));
      check("min_y", 32'(y1), 32'(e.y1));
      check("min_y_raw", 32'(y_raw1), 32'(e.y_raw1));
      check("min_chg", 32'(chg1), 32'(e.chg1));
    end
  end

  initial begin
    int idx;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (20) step();

    // Channel 0 falls after SYNC_STAGES+FILT_CNT edges
    a[1:0] = 2'b01;
    a1     = 1'b1;
    repeat (10) step();
    a[1:0] = 2'b00;
    a1     = 1'b0;
    repeat (10) step();

    // Glitch of FC-1 cycles is rejected, FC cycles passes
    a[2] = 1'b1; repeat (3) step();
    a[2] = 1'b0; repeat (10) step();
    a[2] = 1'b1; repeat (4) step();
    a[2] = 1'b0; repeat (12) step();

    // Bypass: follow with SYNC_STAGES+1 latency, then freeze with en=0
    bypass = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a[4] = ~a[4];
      repeat (2) step();
    end
    en   = 1'b0;
    a[4] = ~a[4];
    repeat (5) step();
    en = 1'b1;
    repeat (4) step();
    bypass = 1'b0;
    a[4]   = 1'b0;
    repeat (8) step();

    // Reset in the middle of a pending change
    a[6] = 1'b1;
    repeat (4) step();
    assert_reset();
    a = '0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (12) step();

    // Randomised phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx    = int'($urandom_range(0, N - 1));
        a[idx] = ~a[idx];
      end
      if ($urandom_range(0, 2) == 0) a1 = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 59) == 0) bypass = ~bypass;
      step();
      if ($urandom_range(0, 399) == 0) begin
        assert_reset();
        step();
        rst_n = 1'b1;
      end
    end

    bypass = 1'b0;
    en     = 1'b1;
    repeat (10) step();
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
